// File: rtl/usb_ep_arbiter.sv
// usb_ep_arbiter
//   Shares the usb_fs_pe endpoint buffer and packet datapath among NUM_EPS
//   endpoint requesters. Round-robin req/grant with hold. The owner is never
//   preempted by other requests. A release is deferred while the protocol
//   engine is mid-packet. Every owner change passes through one all-zero GAP
//   cycle. A saturating watchdog forcibly reclaims a grant that is held too long.
//
// Ports
//   clk          in   48 MHz system clock
//   reset_n      in   async active-low reset
//   req          in   [NUM_EPS] per-endpoint level request
//   pe_busy      in   protocol engine mid-packet; freezes ownership
//   grant        out  [NUM_EPS] one-hot/zero grant, registered
//   grant_valid  out  OR of grant, registered
//   grant_idx    out  owner index, 0 when no owner, registered
//   timeout_err  out  1-cycle pulse when the watchdog reclaims a grant
//
// Configuration macro
//   USB_EP_ARB_CTRL_PRIORITY_EN : ep0 gets strict priority in IDLE/GAP. An ep0
//   release does not move the round-robin pointer.
module usb_ep_arbiter #(
  parameter int NUM_EPS   = 4,
  parameter int TIMEOUT_W = 12,
  localparam int IDX_W    = $clog2(NUM_EPS)
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [NUM_EPS-1:0] req,
  input  logic               pe_busy,
  output logic [NUM_EPS-1:0] grant,
  output logic               grant_valid,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               timeout_err
);

  typedef enum logic [1:0] {S_IDLE, S_GRANTED, S_GAP} state_t;

  state_t               r_state;
  logic [IDX_W-1:0]     r_rr_ptr;
  logic [TIMEOUT_W-1:0] r_wd;
  logic [NUM_EPS-1:0]   r_grant;
  logic                 r_grant_valid;
  logic [IDX_W-1:0]     r_grant_idx;
  logic                 r_timeout_err;

  logic                 w_win_found;
  logic [IDX_W-1:0]     w_win_idx;
  logic [NUM_EPS-1:0]   w_win_oh;
  logic [TIMEOUT_W-1:0] w_wd_inc;
  logic                 w_wd_to;
  logic                 w_release;
  logic                 w_adv_ptr;
  logic [IDX_W-1:0]     w_ptr_next;

  // Winner search from rr_ptr upward with wrap. The scan runs from the far end
  // back toward rr_ptr, so the last hit is the closest requester.
  always_comb begin
    w_win_found = 1'b0;
    w_win_idx   = '0;
    for (int k = NUM_EPS-1; k >= 0; k--) begin
      int j;
      j = int'(r_rr_ptr) + k;
      if (j >= NUM_EPS) j = j - NUM_EPS;
      if (req[IDX_W'(j)]) begin
        w_win_found = 1'b1;
        w_win_idx   = IDX_W'(j);
      end
    end
`ifdef USB_EP_ARB_CTRL_PRIORITY_EN
    if (req[0]) begin
      w_win_found = 1'b1;
      w_win_idx   = '0;
    end
`endif
  end

  assign w_win_oh = NUM_EPS'(1) << w_win_idx;

  // The watchdog counts granted cycles, including the current one. The grant
  // is therefore reclaimed at the end of the (2**TIMEOUT_W-1)-th cycle.
  assign w_wd_inc  = (&r_wd) ? r_wd : r_wd + 1'b1;
  assign w_wd_to   = &w_wd_inc;
  assign w_release = !pe_busy && (!req[r_grant_idx] || w_wd_to);

`ifdef USB_EP_ARB_CTRL_PRIORITY_EN
  assign w_adv_ptr = (r_grant_idx != '0);
`else
  assign w_adv_ptr = 1'b1;
`endif
  assign w_ptr_next = (r_grant_idx == IDX_W'(NUM_EPS-1)) ? '0 : r_grant_idx + 1'b1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= S_IDLE;
      r_rr_ptr      <= '0;
      r_wd          <= '0;
      r_grant       <= '0;
      r_grant_valid <= 1'b0;
      r_grant_idx   <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      r_timeout_err <= 1'b0;
      case (r_state)
        S_IDLE, S_GAP: begin
          if (w_win_found) begin
            r_state       <= S_GRANTED;
            r_grant       <= w_win_oh;
            r_grant_valid <= 1'b1;
            r_grant_idx   <= w_win_idx;
            r_wd          <= '0;
          end else begin
            r_state       <= S_IDLE;
            r_grant       <= '0;
            r_grant_valid <= 1'b0;
            r_grant_idx   <= '0;
          end
        end
        S_GRANTED: begin
          if (w_release) begin
            r_state       <= S_GAP;
            r_grant       <= '0;
            r_grant_valid <= 1'b0;
            r_grant_idx   <= '0;
            r_timeout_err <= w_wd_to;
            if (w_adv_ptr) r_rr_ptr <= w_ptr_next;
          end else begin
            r_wd <= w_wd_inc;
          end
        end
        default: begin
          r_state       <= S_IDLE;
          r_grant       <= '0;
          r_grant_valid <= 1'b0;
          r_grant_idx   <= '0;
        end
      endcase
    end
  end

  assign grant       = r_grant;
  assign grant_valid = r_grant_valid;
  assign grant_idx   = r_grant_idx;
  assign timeout_err = r_timeout_err;

endmodule

// File: tb/tb_usb_ep_arbiter.sv
module tb_usb_ep_arbiter;
  localparam int N  = 4;
  localparam int TW = 4;
  localparam int WD_MAX = (1 << TW) - 1;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic [N-1:0] req = '0;
  logic         pe_busy = 1'b0;
  logic [N-1:0] grant;
  logic         grant_valid;
  logic [1:0]   grant_idx;
  logic         timeout_err;

  int n_chk = 0;
  int n_err = 0;

  // Reference model: the current owner (-1 when there is none), the round-robin pointer,
  // the granted-cycle count and the timeout pulse.
  int m_owner = -1;
  int m_ptr   = 0;
  int m_held  = 0;
  bit m_tmo   = 0;

  usb_ep_arbiter #(.NUM_EPS(N), .TIMEOUT_W(TW)) dut (
    .clk(clk), .reset_n(reset_n), .req(req), .pe_busy(pe_busy),
    .grant(grant), .grant_valid(grant_valid), .grant_idx(grant_idx),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_owner = -1; m_ptr = 0; m_held = 0; m_tmo = 0;
  endtask

  task automatic model_edge(input logic [N-1:0] r, input logic b);
    m_tmo = 0;
    if (m_owner < 0) begin
      int w;
      w = -1;
`ifdef USB_EP_ARB_CTRL_PRIORITY_EN
      if (r[0]) w = 0;
`endif
      for (int k = 0; k < N; k++)
        if (w < 0 && r[(m_ptr + k) % N]) w = (m_ptr + k) % N;
      if (w >= 0) begin
        m_owner = w;
        m_held  = 0;
      end
    end else begin
      if (m_held < WD_MAX) m_held++;
      if (!b && (!r[m_owner] || m_held == WD_MAX)) begin
        m_tmo = (m_held == WD_MAX);
`ifdef USB_EP_ARB_CTRL_PRIORITY_EN
        if (m_owner != 0) m_ptr = (m_owner + 1) % N;
`else
        m_ptr = (m_owner + 1) % N;
`endif
        m_owner = -1;
      end
    end
  endtask

  task automatic check_model(input string tag);
    logic [N-1:0] eg;
    eg = (m_owner >= 0) ? N'(1 << m_owner) : '0;
    chk({tag, ".grant"}, 32'(grant), 32'(eg));
    chk({tag, ".valid"}, 32'(grant_valid), 32'(m_owner >= 0));
    chk({tag, ".idx"}, 32'(grant_idx), (m_owner >= 0) ? 32'(m_owner) : 32'd0);
    chk({tag, ".tmo"}, 32'(timeout_err), 32'(m_tmo));
  endtask

  // Drive one cycle of inputs, let the edge happen, then compare against the model.
  task automatic step(input string tag, input logic [N-1:0] r, input logic b);
    req = r;
    pe_busy = b;
    @(posedge clk);
    model_edge(r, b);
    #1;
    check_model(tag);
  endtask

  task automatic do_reset();
    req = '0;
    pe_busy = 1'b0;
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    model_reset();
  endtask

  initial begin
    // reset with every request pending
    reset_n = 1'b0;
    req = 4'b1111;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.grant", 32'(grant), 32'd0);
    chk("rst.valid", 32'(grant_valid), 32'd0);
    chk("rst.idx", 32'(grant_idx), 32'd0);
    chk("rst.tmo", 32'(timeout_err), 32'd0);

    // single requester, 1-cycle latency, release on drop
    do_reset();
    step("t2", 4'b0100, 1'b0);
    for (int c = 1; c <= 4; c++) begin
      chk("t2.hold", 32'(grant), 32'b0100);
      chk("t2.idx", 32'(grant_idx), 32'd2);
      step("t2", 4'b0100, 1'b0);
    end
    chk("t2.c5", 32'(grant), 32'b0100);
    step("t2", 4'b0000, 1'b0);
    chk("t2.c6", 32'(grant), 32'd0);

    // full round-robin rotation with one gap cycle between owners
    do_reset();
    begin
      int seq[$];
      int cnt = 0, zeros = 0;
      logic prev_v = 1'b0;
      logic [N-1:0] r = 4'b1111;
      for (int c = 0; c < 60 && seq.size() < 5; c++) begin
        step("t3", r, 1'b0);
        if (grant_valid && !prev_v) begin
          if (seq.size() > 0) chk("t3.gap", 32'(zeros), 32'd1);
          seq.push_back(int'(grant_idx));
          cnt = 0;
        end
        if (!grant_valid) zeros++; else zeros = 0;
        r = 4'b1111;
        if (grant_valid) begin
          cnt++;
          if (cnt >= 3) r[grant_idx] = 1'b0;
        end
        prev_v = grant_valid;
      end
      chk("t3.n", 32'(seq.size()), 32'd5);
      if (seq.size() == 5)
        for (int i = 0; i < 5; i++) chk("t3.owner", 32'(seq[i]), 32'(i % N));
    end

    // release deferred by pe_busy
    do_reset();
    step("t4", 4'b0010, 1'b0);
    step("t4", 4'b0010, 1'b0);
    for (int c = 0; c < 4; c++) begin
      step("t4", 4'b0000, 1'b1);
      chk("t4.held", 32'(grant), 32'b0010);
    end
    step("t4", 4'b0000, 1'b0);
    chk("t4.rel", 32'(grant), 32'd0);

    // watchdog reclaim of a stuck requester
    do_reset();
    begin
      logic [N-1:0] obs[20];
      int n1 = 0, ntmo = 0;
      for (int c = 0; c < 20; c++) begin
        step("t5", 4'b1010, 1'b0);
        obs[c] = grant;
        if (grant == 4'b0010) n1++;
        if (timeout_err) ntmo++;
      end
      chk("t5.n1", 32'(n1), 32'd15);
      chk("t5.ntmo", 32'(ntmo), 32'd1);
      chk("t5.gap", 32'(obs[15]), 32'd0);
      chk("t5.next", 32'(obs[16]), 32'b1000);
    end

    // rr_ptr=2 and req 0101 presented during the GAP cycle
    do_reset();
    step("t6", 4'b0010, 1'b0);
    step("t6", 4'b0000, 1'b0);
    step("t6", 4'b0101, 1'b0);
`ifdef USB_EP_ARB_CTRL_PRIORITY_EN
    chk("t6.win", 32'(grant), 32'b0001);
`else
    chk("t6.win", 32'(grant), 32'b0100);
`endif

    // async reset in the middle of a grant clears outputs at once
    do_reset();
    step("t7", 4'b0001, 1'b0);
    #3;
    reset_n = 1'b0;
    #1;
    chk("t7.grant", 32'(grant), 32'd0);
    chk("t7.valid", 32'(grant_valid), 32'd0);
    chk("t7.idx", 32'(grant_idx), 32'd0);
    chk("t7.tmo", 32'(timeout_err), 32'd0);

    // randomized traffic against the model
    do_reset();
    begin
      logic [N-1:0] r = '0;
      logic b;
      for (int c = 0; c < 3000; c++) begin
        for (int i = 0; i < N; i++)
          if ($urandom_range(7) == 0) r[i] = ~r[i];
        b = ($urandom_range(3) == 0);
        step("rnd", r, b);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
